// File: rtl/ex_wb_pipe_stage.sv
// rtl/ex_wb_pipe_stage.sv - EX->WB pipeline register with valid/ready handshake, 2-entry skid buffer, flush and forwarding tap
module ex_wb_pipe_stage #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned BANK_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BANK_WIDTH-1:0] regs_bank_in,
    input  logic [DATA_WIDTH-1:0] mux2_in,
    input  logic [DATA_WIDTH-1:0] pc_in,
    input  logic [ADDR_WIDTH-1:0] regC_adress_in,
    input  logic                  write_inst_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BANK_WIDTH-1:0] regs_bank_out,
    output logic [DATA_WIDTH-1:0] mux2_out,
    output logic [DATA_WIDTH-1:0] pc_out,
    output logic [ADDR_WIDTH-1:0] regC_adress_out,
    output logic                  write_inst_out,
    output logic                  fwd_valid,
    output logic [ADDR_WIDTH-1:0] fwd_addr,
    output logic [DATA_WIDTH-1:0] fwd_data
);

    // Packed payload: {bank, mux2, pc, addr, write}
    localparam int unsigned PW = BANK_WIDTH + 2 * DATA_WIDTH + ADDR_WIDTH + 1;

    logic [PW-1:0] in_pld;
    logic [PW-1:0] main_q, main_d;
    logic [PW-1:0] skid_q, skid_d;
    logic          main_valid_q, main_valid_d;
    logic          skid_valid_q, skid_valid_d;
    logic          in_ready_q, in_ready_d;
    logic          accept;
    logic          pop;
    logic          held_write;

    assign in_pld = {regs_bank_in, mux2_in, pc_in, regC_adress_in, write_inst_in};
    assign accept = in_valid & in_ready_q;
    assign pop    = main_valid_q & out_ready;

    // Next-state: the {skid, main} valid pair encodes EMPTY / ONE / FULL
    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            // Payload is left as-is; only the valid bits matter after a kill
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else begin
            case ({skid_valid_q, main_valid_q})
                2'b00: begin
                    if (accept) begin
                        main_d       = in_pld;
                        main_valid_d = 1'b1;
                    end
                end
                2'b01: begin
                    if (accept && pop) begin
                        main_d = in_pld;
                    end else if (accept) begin
                        skid_d       = in_pld;
                        skid_valid_d = 1'b1;
                    end else if (pop) begin
                        main_valid_d = 1'b0;
                    end
                end
                2'b11: begin
                    // in_ready is low here, so only a pop can move state
                    if (pop) begin
                        main_d       = skid_q;
                        skid_valid_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end
        // Registered ready: accept only when the skid slot is free after this edge
        in_ready_d = ~skid_valid_d;
    end

    // State registers; reset clears payload too so outputs read as zero
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign {regs_bank_out, mux2_out, pc_out, regC_adress_out, held_write} = main_q;

    // A stale or flushed entry must never reach the register bank
    assign out_valid      = main_valid_q;
    assign in_ready       = in_ready_q;
    assign write_inst_out = held_write & main_valid_q;
    assign fwd_valid      = held_write & main_valid_q;
    assign fwd_addr       = regC_adress_out;
    assign fwd_data       = mux2_out;

endmodule

// File: doc/ex_wb_pipe_stage.md
Name: ex_wb_pipe_stage

Overview:
- Parametrised EX→WB pipeline register.
- Successor to the fixed-width, always-loading EX/WB register.
- Adds valid/ready handshake, a 2-entry skid buffer (full throughput with a registered in_ready), synchronous flush, and a write-back forwarding tap for the hazard unit.
- Sits between the execute stage (mux2 result, pc, destination address) and register-bank write-back.

Parameters:
- DATA_WIDTH, 32, width of mux2 and pc fields
- ADDR_WIDTH, 4, width of the regC destination address
- BANK_WIDTH, 2, width of the register-bank select

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- flush  in  1  synchronous kill of all held entries
- in_valid  in  1  EX presents a valid instruction
- in_ready  out  1  stage can accept (registered)
- regs_bank_in  in  BANK_WIDTH  register-bank select
- mux2_in  in  DATA_WIDTH  EX result
- pc_in  in  DATA_WIDTH  instruction pc
- regC_adress_in  in  ADDR_WIDTH  destination register
- write_inst_in  in  1  instruction writes regC
- out_valid  out  1  WB holds a valid instruction
- out_ready  in  1  WB consumes this cycle
- regs_bank_out  out  BANK_WIDTH  held bank select
- mux2_out  out  DATA_WIDTH  held result
- pc_out  out  DATA_WIDTH  held pc
- regC_adress_out  out  ADDR_WIDTH  held destination
- write_inst_out  out  1  held write enable, gated by out_valid
- fwd_valid  out  1  out_valid & write_inst of head entry
- fwd_addr  out  ADDR_WIDTH  = regC_adress_out
- fwd_data  out  DATA_WIDTH  = mux2_out

Behaviour:

Storage:
- Main register drives the outputs; a skid register holds overflow. Each has its own valid bit.
- State is derived from the valid bits: EMPTY (none), ONE (main only), FULL (main + skid).
- in_ready is a flop output, equal to !skid_valid after each edge.
- accept = in_valid & in_ready.
- pop = out_valid & out_ready.

Transitions (per rising edge, rst_n=1, flush=0):
- EMPTY, accept → ONE; main loads the inputs.
- ONE, accept & pop → ONE; main loads the inputs.
- ONE, accept & !pop → FULL; skid loads the inputs; in_ready→0.
- ONE, !accept & pop → EMPTY.
- FULL, pop → ONE; main←skid; in_ready→1. accept is impossible here because in_ready=0.
- Otherwise hold all payload and valid bits.

Ordering and latency:
- Order is strict FIFO.
- Latency: 1 cycle from input accept to out_valid when EMPTY.
- Throughput: 1 instruction per cycle while out_ready=1.

Output gating:
- write_inst_out and fwd_valid are forced to 0 whenever out_valid=0, so a stale or flushed entry never writes the register bank.
- Other payload outputs hold their last value when out_valid=0.

Flush:
- On an edge with flush=1, both valid bits clear and in_ready→1.
- Flush overrides accept and pop in the same cycle; the input is dropped.
- Payload registers need not clear on flush.

Reset:
- On an edge with rst_n=0: out_valid=0, skid_valid=0, in_ready=1.
- All payload outputs are 0, write_inst_out=0, fwd_valid=0.
- Reset overrides flush, accept and pop.
- Reset mid-FULL discards both entries.

Boundaries:
- FULL with out_ready held low: hold indefinitely; inputs are ignored (in_ready=0).
- Entries are transparent to values: DATA_WIDTH fields pass unmodified. No arithmetic, no wrap.

Test Plan:
1. Pass-through: reset, out_ready=1. Present {write=1, bank=2, addr=9, mux2=200, pc=620}, then {0, 3, 12, 160, 450} on consecutive cycles → each appears one cycle after accept in order. write_inst_out=1 then 0. fwd_valid=1, fwd_addr=9, fwd_data=200 on the first entry only.
2. Backpressure/skid: out_ready=0. Accept A(pc=620) then B(pc=450) → in_ready=0 after B, outputs hold A. Raise out_ready → A pops, B appears next cycle, in_ready=1. Nothing lost or duplicated.
3. Flush in FULL: FULL state, assert flush with in_valid=1 and pc=100 → next cycle out_valid=0, write_inst_out=0, in_ready=1. pc=100 is never output.
4. Simultaneous accept+pop in ONE, 8-cycle stream pc=0,4,…,28 with out_ready=1 → out_valid stays 1, outputs pc=0..28 in order, in_ready never drops.
5. Reset mid-operation: FULL state with write=1, addr=9, then rst_n=0 for one edge → all outputs 0, out_valid=0, in_ready=1. A new entry after reset passes normally.
6. Parameter sweep: DATA_WIDTH=16, ADDR_WIDTH=5, BANK_WIDTH=3; mux2=16'hFFFF, addr=31, bank=7 → held exactly, no truncation.
